operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Parametrised successor to the pipeline's register-read stage. Reads NUM_SRC source operands per instruction and resolves data hazards against NUM_FWD generic forwarding stages.
- Each forwarding stage reports its destination register and whether its result is already available. Opcode decoding is therefore moved upstream; this block never decodes opcodes.
- New versus the previous generation:
  - downstream back-pressure (out_hold),
  - pipeline flush,
  - a saturating hazard-stall performance counter,
  - a sticky stall-timeout watchdog.
- Sits between decode and execute. Output is registered with 1-cycle latency.

Parameters:
- XLEN, 32, operand width in bits.
- NUM_SRC, 2, source operands per instruction (1..4).
- NUM_FWD, 4, forwarding stages. Index 0 is the youngest (closest to this stage).
- REG_W, 5, register index width. Register 0 is hardwired zero.
- CNT_W, 16, width of the stall performance counter.
- TIMEOUT, 64, consecutive hazard-stall cycles that trigger stall_timeout (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- in_noop  in  1  current instruction is a bubble.
- in_rs  in  NUM_SRC*REG_W  source register indices; slot i is at bits [i*REG_W +: REG_W].
- rf_rdata  in  NUM_SRC*XLEN  register-file read data, one slot per source.
- fwd_valid  in  NUM_FWD  stage k holds a non-bubble instruction that writes a register.
- fwd_rd  in  NUM_FWD*REG_W  destination register of stage k.
- fwd_avail  in  NUM_FWD  stage k's result is final and forwardable.
- fwd_data  in  NUM_FWD*XLEN  result of stage k.
- out_hold  in  1  downstream cannot accept a new instruction this cycle.
- flush  in  1  squash the current instruction.
- stall  out  1  upstream must hold its instruction.
- out_noop  out  1  registered bubble flag to execute.
- out_rs_data  out  NUM_SRC*XLEN  registered operands.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_noop=1, out_rs_data=0, stall_count=0, stall_timeout=0.
  - Internal consecutive-stall counter cleared.
  - Reset mid-stall abandons the instruction. No state survives.
- Per source i, combinational, when in_noop=0 and in_rs[i]!=0:
  - Find the lowest k with fwd_valid[k]=1 and fwd_rd[k]==in_rs[i]. The youngest stage wins; older matches are ignored.
  - Match with fwd_avail[k]=1: operand = fwd_data[k].
  - Match with fwd_avail[k]=0: hz[i]=1 and operand = rf_rdata[i] (don't-care).
  - No match: operand = rf_rdata[i].
  - Register index 0, or in_noop=1, never matches and never stalls. Operand = rf_rdata[i].
- Stall signals:
  - hazard = OR of hz[i].
  - stall = hazard OR out_hold, evaluated combinationally in the same cycle.
- Output register update, at each posedge in priority order:
  1. flush=1: out_noop<=1; out_rs_data unchanged. Flush overrides out_hold.
  2. out_hold=1: all outputs hold.
  3. Otherwise: out_noop <= in_noop OR hazard; out_rs_data <= resolved operands.
- Latency is 1 cycle from an accepted instruction to out_noop=0.
- stall_count:
  - Increments on each posedge where hazard=1 and flush=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - out_hold-only stalls are not counted.
- Watchdog:
  - The consecutive counter increments while hazard=1 and flush=0, and clears otherwise.
  - When it reaches TIMEOUT, stall_timeout<=1 and stays set until rst.
  - The counter saturates at TIMEOUT.
- Simultaneous events:
  - hazard and out_hold together: stall=1, outputs hold, stall_count still increments.
  - flush and hazard together: bubble issued, no count.
- Arithmetic: all comparisons are unsigned REG_W equality. Data passes through unmodified at XLEN.

Test Plan:
- No hazard: in_rs={2,1}, rf_rdata={0x22,0x11}, fwd_valid=0 -> next cycle out_noop=0, out_rs_data={0x22,0x11}, stall=0.
- Youngest-wins forwarding: rs1=5, fwd_valid=0b0101, fwd_rd[0]=5 with data 0xAAAA, fwd_rd[2]=5 with data 0xBBBB, both avail -> operand 0xAAAA.
- Unavailable result (load-use): rs2=7, fwd_rd[1]=7, avail=0 for 3 cycles, then avail=1 with data 0x1234 -> stall=1 and out_noop=1 for 3 cycles, stall_count=3, then operand 0x1234 with out_noop=0.
- x0 and bubble immunity: rs1=0 with fwd_rd[0]=0 unavailable -> no stall; in_noop=1 with matching unavailable stage -> no stall, out_noop=1.
- Hold/flush priority: out_hold=1 for 2 cycles -> outputs frozen, stall=1, stall_count unchanged; then flush=1 together with out_hold=1 -> out_noop=1 next cycle.
- Watchdog and reset: TIMEOUT=4, hazard held 4 cycles -> stall_timeout=1 and remains set after the hazard clears; assert rst mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch.sv
// Register-read stage: resolves source operands against a generic forwarding
// network, stalls on unavailable results, and counts / watches hazard stalls.
module operand_fetch #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_noop,
  input  logic [NUM_SRC*REG_W-1:0] in_rs,
  input  logic [NUM_SRC*XLEN-1:0]  rf_rdata,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]       fwd_avail,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  input  logic                     out_hold,
  input  logic                     flush,
  output logic                     stall,
  output logic                     out_noop,
  output logic [NUM_SRC*XLEN-1:0]  out_rs_data,
  output logic [CNT_W-1:0]         stall_count,
  output logic                     stall_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [NUM_SRC-1:0]      hz;
  logic [NUM_SRC*XLEN-1:0] opnd;
  logic                    hazard;
  logic                    count_stall;

  logic                    out_noop_q, out_noop_d;
  logic [NUM_SRC*XLEN-1:0] out_rs_data_q, out_rs_data_d;
  logic [CNT_W-1:0]        stall_count_q, stall_count_d;
  logic [TW-1:0]           cons_q, cons_d;
  logic                    stall_timeout_q, stall_timeout_d;

  // Stages are scanned oldest to youngest so the youngest match overwrites.
  always_comb begin
    hz   = '0;
    opnd = rf_rdata;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = 0; j < NUM_FWD; j++) begin
        if (!in_noop && (in_rs[i*REG_W +: REG_W] != '0) &&
            fwd_valid[NUM_FWD-1-j] &&
            (fwd_rd[(NUM_FWD-1-j)*REG_W +: REG_W] == in_rs[i*REG_W +: REG_W])) begin
          hz[i] = !fwd_avail[NUM_FWD-1-j];
          opnd[i*XLEN +: XLEN] = fwd_avail[NUM_FWD-1-j] ?
                                 fwd_data[(NUM_FWD-1-j)*XLEN +: XLEN] :
                                 rf_rdata[i*XLEN +: XLEN];
        end
      end
    end
    hazard      = |hz;
    stall       = hazard | out_hold;
    count_stall = hazard & ~flush;
  end

  always_comb begin
    out_noop_d    = out_noop_q;
    out_rs_data_d = out_rs_data_q;
    if (flush) begin
      out_noop_d = 1'b1;
    end else if (!out_hold) begin
      out_noop_d    = in_noop | hazard;
      out_rs_data_d = opnd;
    end

    stall_count_d = stall_count_q;
    if (count_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    cons_d = '0;
    if (count_stall) begin
      cons_d = (cons_q == TW'(TIMEOUT)) ? cons_q : cons_q + TW'(1);
    end
    stall_timeout_d = stall_timeout_q | (cons_d == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_noop_q      <= 1'b1;
      out_rs_data_q   <= '0;
      stall_count_q   <= '0;
      cons_q          <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      out_noop_q      <= out_noop_d;
      out_rs_data_q   <= out_rs_data_d;
      stall_count_q   <= stall_count_d;
      cons_q          <= cons_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign out_noop      = out_noop_q;
  assign out_rs_data   = out_rs_data_q;
  assign stall_count   = stall_count_q;
  assign stall_timeout = stall_timeout_q;

endmodule
